fp_mult_sequencer: RTL

FP_MULT_SEQUENCER -- requirements
Module: fp_mult_sequencer

---
 rtl/fp_mult_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fp_mult_sequencer.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa loop plus one normalise cycle.
// Define FP_MULT_ROUND_EN for round-to-nearest-even; the default build truncates. Latency is the same in both builds.
module fp_mult_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        is_special
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [23:0]       mcand_q,   mcand_d;
    logic [23:0]       mplier_q,  mplier_d;
    logic              sign_q,    sign_d;
    logic signed [9:0] exp_q,     exp_d;
    logic [4:0]        cnt_q,     cnt_d;
    logic [47:0]       prod_q,    prod_d;
    logic [31:0]       result_q,  result_d;
    logic              special_q, special_d;

    logic [7:0]        ea, eb;
    logic              any_zero, any_inf;
    logic [47:0]       addend;
    logic [22:0]       frac_trunc;
    logic              round_up;
    logic [23:0]       frac_rnd;
    logic signed [9:0] exp_norm, exp_final;
    logic [31:0]       packed_res;

    assign ea       = operand_a[30:23];
    assign eb       = operand_b[30:23];
    assign any_zero = (ea == 8'd0) || (eb == 8'd0);
    assign any_inf  = (ea == 8'hFF) || (eb == 8'hFF);

    assign addend = mplier_q[cnt_q] ? ({24'd0, mcand_q} << cnt_q) : 48'd0;

    // Normalise the product in prod_q, round (or truncate), then clamp to inf/zero.
    always_comb begin
        if (prod_q[47]) begin
            frac_trunc = prod_q[46:24];
            exp_norm   = exp_q + 10'sd1;
        end else begin
            frac_trunc = prod_q[45:23];
            exp_norm   = exp_q;
        end
`ifdef FP_MULT_ROUND_EN
        if (prod_q[47]) begin
            round_up = prod_q[23] & ((|prod_q[22:0]) | frac_trunc[0]);
        end else begin
            round_up = prod_q[22] & ((|prod_q[21:0]) | frac_trunc[0]);
        end
`else
        round_up = 1'b0;
`endif
        frac_rnd  = {1'b0, frac_trunc} + {23'd0, round_up};
        // A carry out of the fraction leaves the field all zeros; only the exponent moves.
        exp_final = exp_norm + (frac_rnd[23] ? 10'sd1 : 10'sd0);
        if (exp_final >= 10'sd255) begin
            packed_res = {sign_q, 8'hFF, 23'd0};
        end else if (exp_final <= 10'sd0) begin
            packed_res = 32'd0;
        end else begin
            packed_res = {sign_q, exp_final[7:0], frac_rnd[22:0]};
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        result_d  = result_q;
        special_d = special_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = {1'b1, operand_a[22:0]};
                    mplier_d = {1'b1, operand_b[22:0]};
                    sign_d   = operand_a[31] ^ operand_b[31];
                    exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                    cnt_d    = 5'd0;
                    prod_d   = 48'd0;
                    if (any_zero) begin
                        result_d  = 32'd0;
                        special_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (any_inf) begin
                        result_d  = {operand_a[31] ^ operand_b[31], 8'hFF, 23'd0};
                        special_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_MULT;
                    end
                end
            end
            S_MULT: begin
                prod_d = prod_q + addend;
                if (cnt_q == 5'd23) begin
                    cnt_d   = 5'd0;
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_NORM: begin
                result_d  = packed_res;
                special_d = 1'b0;
                state_d   = S_DONE;
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= 24'd0;
            mplier_q  <= 24'd0;
            sign_q    <= 1'b0;
            exp_q     <= 10'sd0;
            cnt_q     <= 5'd0;
            prod_q    <= 48'd0;
            result_q  <= 32'd0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            result_q  <= result_d;
            special_q <= special_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign result     = result_q;
    assign is_special = special_q;

endmodule
